// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0080;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch front end: single-outstanding req/gnt/rvalid master feeding
// a small instruction buffer, with branch redirect flush and stale-response discard.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_pc_o,
  input  logic        id_ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 2;

  fetch_state_e     state_q, state_d;
  logic [31:0]      next_addr_q, req_addr_q, inflight_pc_q;
  logic             discard_q;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             wait_rv, pop, push, room, issue, stale_req, grant;
  logic [OCC_W-1:0] occ_after;
  fetch_entry_t     head;

  assign wait_rv   = (state_q == WAIT) & instr_rvalid_i;
  assign pop       = instr_valid_o & id_ready_i;
  assign push      = wait_rv & ~discard_q & ~branch_i;
  assign stale_req = (state_q == REQ) & discard_q;
  assign grant     = instr_req_o & instr_gnt_i;

  // Room for one more request: buffered entries plus the response landing this
  // cycle plus the new request must fit once the current head is consumed.
  assign occ_after = OCC_W'(fifo_count) + OCC_W'(push) + OCC_W'(1);
  assign room      = occ_after <= (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));
  assign issue     = rst_ni & fetch_enable_i & ~branch_i & room;

  assign instr_req_o  = (state_q == REQ) | (issue & ((state_q == IDLE) | wait_rv));
  assign instr_addr_o = (state_q == REQ) ? req_addr_q : next_addr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (instr_req_o) state_d = instr_gnt_i ? WAIT : REQ;
      REQ:  if (instr_gnt_i) state_d = WAIT;
      WAIT: if (instr_rvalid_i) begin
              if (instr_req_o) state_d = instr_gnt_i ? WAIT : REQ;
              else             state_d = IDLE;
            end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      next_addr_q   <= BOOT_ADDR;
      req_addr_q    <= '0;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_req_o & ~instr_gnt_i) req_addr_q <= instr_addr_o;
      if (grant) inflight_pc_q <= instr_addr_o;
      // A held request granted after a redirect must not disturb the new target.
      if (branch_i)
        next_addr_q <= {branch_target_i[31:2], 2'b00};
      else if (grant & ~stale_req)
        next_addr_q <= instr_addr_o + 32'd4;
      if (branch_i & ((state_q == REQ) | ((state_q == WAIT) & ~instr_rvalid_i)))
        discard_q <= 1'b1;
      else if (wait_rv)
        discard_q <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .flush  (branch_i),
    .wdata  ('{instr: instr_rdata_i, pc: inflight_pc_q}),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign instr_valid_o = ~fifo_empty;
  assign instr_rdata_o = fifo_empty ? '0 : head.instr;
  assign instr_pc_o    = fifo_empty ? '0 : head.pc;

  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: cycle table, directed corner cases,
// and randomized bus/decode/redirect traffic checked against a stream model.
module tb_instr_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        fetch_enable = 1'b0, instr_gnt = 1'b0, instr_rvalid = 1'b0;
  logic [31:0] instr_rdata = '0;
  logic        branch = 1'b0, id_ready = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_req, instr_valid;
  logic [31:0] instr_addr, dec_rdata, instr_pc;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .BOOT_ADDR  (BOOT),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .fetch_enable_i  (fetch_enable),
    .instr_req_o     (instr_req),
    .instr_addr_o    (instr_addr),
    .instr_gnt_i     (instr_gnt),
    .instr_rvalid_i  (instr_rvalid),
    .instr_rdata_i   (instr_rdata),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .instr_valid_o   (instr_valid),
    .instr_rdata_o   (dec_rdata),
    .instr_pc_o      (instr_pc),
    .id_ready_i      (id_ready)
  );

  int tests = 0, fails = 0;

  // Stimulus knobs
  bit          fe, rdy, br;
  logic [31:0] tgt;

  // Memory responder
  bit          outstanding, rand_bus;
  logic [31:0] out_addr;
  int          rv_wait, rv_delay, gnt_delay, hold_cnt, hold_at_grant;

  // Stream model
  logic [31:0] exp_pop_pc, exp_fetch, prev_addr, last_grant_addr;
  bit          stale_req, prev_pending, prev_branch, granted_now;
  int          pops, grants;

  // Samples
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_rdata, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  task automatic clear_model();
    outstanding = 0; hold_cnt = 0; rv_wait = 0;
    prev_pending = 0; prev_branch = 0; stale_req = 0;
    exp_pop_pc = BOOT; exp_fetch = BOOT;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    fe = 0; br = 0; rdy = 0;
    fetch_enable = 0; branch = 0; id_ready = 0; instr_gnt = 0; instr_rvalid = 0;
    #1;
    chk("rst_req", 32'(instr_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_rdata", dec_rdata, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr", instr_addr, BOOT);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // One clock: drive at negedge, settle, sample, answer the bus, update the model.
  task automatic step();
    @(negedge clk);
    if (outstanding && rv_wait == 0) begin
      instr_rvalid = 1'b1; instr_rdata = mem_word(out_addr);
    end else begin
      instr_rvalid = 1'b0; instr_rdata = $urandom;
    end
    fetch_enable = fe; id_ready = rdy; branch = br; branch_target = tgt;
    instr_gnt = 1'b0;
    #1;
    s_req = instr_req; s_addr = instr_addr; s_valid = instr_valid;
    s_rdata = dec_rdata; s_pc = instr_pc;

    if (prev_branch) chk("flush_valid", 32'(s_valid), 0);
    if (prev_pending) begin
      chk("req_held", 32'(s_req), 1);
      chk("addr_held", s_addr, prev_addr);
    end
    if (outstanding && !instr_rvalid) chk("one_outstanding", 32'(s_req), 0);

    granted_now = 0;
    if (s_req && !(outstanding && !instr_rvalid)) begin
      if (hold_cnt == 0 && rand_bus) gnt_delay = $urandom_range(0, 3);
      if (hold_cnt >= gnt_delay) begin
        instr_gnt = 1'b1; granted_now = 1; hold_at_grant = hold_cnt; hold_cnt = 0;
      end else hold_cnt++;
    end

    if (s_valid && rdy) begin
      chk("pop_pc", s_pc, exp_pop_pc);
      chk("pop_instr", s_rdata, mem_word(s_pc));
      exp_pop_pc += 4;
      pops++;
    end
    if (granted_now) begin
      grants++;
      last_grant_addr = s_addr;
      if (stale_req) stale_req = 0;
      else begin
        chk("grant_addr", s_addr, exp_fetch);
        exp_fetch += 4;
      end
    end
    if (br) begin
      exp_pop_pc = {tgt[31:2], 2'b00};
      exp_fetch  = {tgt[31:2], 2'b00};
      if (s_req && !granted_now) stale_req = 1;
    end

    prev_pending = s_req && !instr_gnt;
    prev_addr    = s_addr;
    prev_branch  = br;

    if (instr_rvalid) outstanding = 0;
    else if (outstanding && rv_wait > 0) rv_wait--;
    if (instr_gnt) begin
      outstanding = 1; out_addr = s_addr;
      if (rand_bus) rv_delay = $urandom_range(0, 2);
      rv_wait = rv_delay;
    end
  endtask

  typedef struct {
    bit          fe, rdy, br;
    logic [31:0] tgt;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input bit f, input bit r, input bit b, input logic [31:0] t,
                              input bit q, input logic [31:0] a, input bit v, input logic [31:0] p);
    vec_t x;
    x.fe = f; x.rdy = r; x.br = b; x.tgt = t; x.req = q; x.addr = a; x.valid = v; x.pc = p;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a1, a2, first_addr;
    int g0, p0;
    bit seen_valid;

    // fe rdy br tgt | req addr valid pc  (zero-wait memory)
    tbl[0]  = mk(1, 1, 0, 0,          1, 32'h80,   0, 0);
    tbl[1]  = mk(1, 1, 0, 0,          1, 32'h84,   0, 0);
    tbl[2]  = mk(1, 1, 0, 0,          1, 32'h88,   1, 32'h80);
    tbl[3]  = mk(1, 1, 0, 0,          1, 32'h8C,   1, 32'h84);
    tbl[4]  = mk(1, 0, 0, 0,          0, 32'h90,   1, 32'h88);
    tbl[5]  = mk(1, 0, 0, 0,          0, 32'h90,   1, 32'h88);
    tbl[6]  = mk(1, 0, 0, 0,          0, 32'h90,   1, 32'h88);
    tbl[7]  = mk(1, 1, 0, 0,          1, 32'h90,   1, 32'h88);
    tbl[8]  = mk(1, 1, 0, 0,          1, 32'h94,   1, 32'h8C);
    tbl[9]  = mk(1, 1, 0, 0,          1, 32'h98,   1, 32'h90);
    tbl[10] = mk(1, 1, 1, 32'h1002,   0, 32'h9C,   1, 32'h94);
    tbl[11] = mk(1, 1, 0, 0,          1, 32'h1000, 0, 0);
    tbl[12] = mk(1, 1, 0, 0,          1, 32'h1004, 0, 0);
    tbl[13] = mk(1, 1, 0, 0,          1, 32'h1008, 1, 32'h1000);
    tbl[14] = mk(0, 1, 0, 0,          0, 32'h100C, 1, 32'h1004);
    tbl[15] = mk(0, 1, 0, 0,          0, 32'h100C, 1, 32'h1008);
    tbl[16] = mk(0, 1, 0, 0,          0, 32'h100C, 0, 0);
    tbl[17] = mk(1, 1, 0, 0,          1, 32'h100C, 0, 0);

    rand_bus = 0; gnt_delay = 0; rv_delay = 0; tgt = '0; pops = 0; grants = 0;
    apply_reset();

    for (int i = 0; i < 18; i++) begin
      fe = tbl[i].fe; rdy = tbl[i].rdy; br = tbl[i].br; tgt = tbl[i].tgt;
      step();
      chk($sformatf("t%0d_req", i), 32'(s_req), 32'(tbl[i].req));
      chk($sformatf("t%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("t%0d_pc", i), s_pc, tbl[i].pc);
      chk($sformatf("t%0d_rdata", i), s_rdata, tbl[i].valid ? mem_word(tbl[i].pc) : 32'h0);
    end
    br = 0; tgt = '0;

    // Grant held off for three cycles
    gnt_delay = 3;
    g0 = grants;
    for (int i = 0; i < 20 && grants == g0; i++) step();
    chk("gnt_seen", 32'(grants != g0), 1);
    chk("gnt_delay_hold", 32'(hold_at_grant), 3);

    // Redirect while a response is still outstanding
    gnt_delay = 0; rv_delay = 2;
    g0 = grants;
    for (int i = 0; i < 20 && grants == g0; i++) step();
    br = 1; tgt = 32'h0000_1002;
    step();
    br = 0;
    g0 = grants; first_addr = 'x; seen_valid = 0;
    for (int i = 0; i < 20 && !seen_valid; i++) begin
      step();
      if (granted_now && grants == g0 + 1) first_addr = s_addr;
      if (s_valid) seen_valid = 1;
    end
    chk("br_first_addr", first_addr, 32'h0000_1000);
    chk("br_first_valid", 32'(seen_valid), 1);
    chk("br_first_pc", s_pc, 32'h0000_1000);

    // Address wrap at the top of the space
    rv_delay = 0;
    g0 = grants;
    for (int i = 0; i < 20 && grants == g0; i++) step();
    br = 1; tgt = 32'hFFFF_FFFC;
    step();
    br = 0;
    g0 = grants; a1 = 'x; a2 = 'x;
    for (int i = 0; i < 20 && grants < g0 + 2; i++) begin
      step();
      if (granted_now && grants == g0 + 1) a1 = s_addr;
      if (granted_now && grants == g0 + 2) a2 = s_addr;
    end
    chk("wrap_addr0", a1, 32'hFFFF_FFFC);
    chk("wrap_addr1", a2, 32'h0000_0000);

    // Reset asserted while waiting for a response
    rv_delay = 2;
    g0 = grants;
    for (int i = 0; i < 20 && grants == g0; i++) step();
    @(posedge clk);
    #2;
    apply_reset();

    // Randomized traffic
    rand_bus = 1;
    for (int i = 0; i < 1500; i++) begin
      fe  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 29) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step();
    end

    // Drain: traffic must keep flowing afterwards
    rand_bus = 0; gnt_delay = 0; rv_delay = 0;
    fe = 1; rdy = 1; br = 0;
    p0 = pops;
    for (int i = 0; i < 20; i++) step();
    chk("drain_progress", 32'(pops > p0 + 5), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
